// File: rtl/csr_trap_ctrl_pkg.sv
// Shared encodings for the CSR trap controller: request kinds, FSM states,
// vector CSR addresses, funct3 op codes and the registered output bundle.
package csr_trap_ctrl_pkg;

   localparam int CSR_ADDR_W = 12;

   localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC_ADDR = 12'h305;
   localparam logic [CSR_ADDR_W-1:0] CSR_MEPC_ADDR  = 12'h341;

   localparam logic [2:0] CSR_OP_CONST = 3'b001;

   // funct3[1:0] selects the op; funct3[2] selects the zimm source
   localparam logic [1:0] F3_NONE = 2'b00;
   localparam logic [1:0] F3_RW   = 2'b01;
   localparam logic [1:0] F3_RS   = 2'b10;
   localparam logic [1:0] F3_RC   = 2'b11;

   typedef enum logic [2:0] {
      KIND_CSR      = 3'd0,
      KIND_ECALL    = 3'd1,
      KIND_EBREAK   = 3'd2,
      KIND_MRET     = 3'd3,
      KIND_MISAL_LD = 3'd4,
      KIND_MISAL_ST = 3'd5,
      KIND_ILL6     = 3'd6,
      KIND_ILL7     = 3'd7
   } req_kind_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_RD_VEC,
      ST_REDIRECT,
      ST_CSR_RD,
      ST_CSR_WR,
      ST_DEAD
   } state_e;

   typedef struct packed {
      logic                  req_ready;
      logic                  csr_r_en;
      logic                  csr_w_en;
      logic [2:0]            csr_op;
      logic [31:0]           csr_in;
      logic [CSR_ADDR_W-1:0] csr_addr;
      logic                  csr_ecall;
      logic                  csr_ebreak;
      logic                  csr_mret;
      logic                  csr_misaligned;
      logic                  csr_misalign_store;
      logic [31:0]           csr_pc;
      logic [31:0]           csr_store_value;
      logic [14:0]           csr_mem_addr;
      logic [4:0]            csr_rd_addr;
      logic                  rd_we;
      logic [4:0]            rd_addr;
      logic [31:0]           rd_wdata;
      logic                  redirect_valid;
      logic [31:0]           redirect_pc;
   } ctrl_out_t;

   function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                             input logic [31:0] old_val,
                                             input logic [31:0] src);
      case (op)
         F3_RS:   return old_val | src;
         F3_RC:   return old_val & ~src;
         default: return src;
      endcase
   endfunction

endpackage

// File: rtl/csr_trap_ctrl_if.sv
// Bundle between execute stage, trap controller and csr_unit.
// master = controller view; slave = the surrounding pipeline/csr_unit view.
interface csr_trap_ctrl_if;
   import csr_trap_ctrl_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   logic [2:0]            req_kind;
   logic [31:0]           req_pc;
   logic [31:0]           req_insn;
   logic [31:0]           req_rs1_val;
   logic [14:0]           req_mem_addr;
   logic [31:0]           req_store_val;

   logic                  csr_r_en;
   logic                  csr_w_en;
   logic [2:0]            csr_op;
   logic [31:0]           csr_in;
   logic [CSR_ADDR_W-1:0] csr_addr;
   logic [31:0]           csr_out;
   logic                  csr_ecall;
   logic                  csr_ebreak;
   logic                  csr_mret;
   logic                  csr_misaligned;
   logic                  csr_misalign_store;
   logic [31:0]           csr_pc;
   logic [31:0]           csr_store_value;
   logic [14:0]           csr_mem_addr;
   logic [4:0]            csr_rd_addr;

   logic                  rd_we;
   logic [4:0]            rd_addr;
   logic [31:0]           rd_wdata;
   logic                  redirect_valid;
   logic [31:0]           redirect_pc;

   modport master (
      input  req_valid, req_kind, req_pc, req_insn, req_rs1_val,
             req_mem_addr, req_store_val, csr_out,
      output req_ready, csr_r_en, csr_w_en, csr_op, csr_in, csr_addr,
             csr_ecall, csr_ebreak, csr_mret, csr_misaligned, csr_misalign_store,
             csr_pc, csr_store_value, csr_mem_addr, csr_rd_addr,
             rd_we, rd_addr, rd_wdata, redirect_valid, redirect_pc
   );

   modport slave (
      output req_valid, req_kind, req_pc, req_insn, req_rs1_val,
             req_mem_addr, req_store_val, csr_out,
      input  req_ready, csr_r_en, csr_w_en, csr_op, csr_in, csr_addr,
             csr_ecall, csr_ebreak, csr_mret, csr_misaligned, csr_misalign_store,
             csr_pc, csr_store_value, csr_mem_addr, csr_rd_addr,
             rd_we, rd_addr, rd_wdata, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/csr_trap_ctrl.sv
// CSR/trap sequencer: one request at a time, drives every csr_unit control,
// returns rd write-back and PC redirect. All outputs come from one register bank.
module csr_trap_ctrl
   import csr_trap_ctrl_pkg::*;
#(
   parameter logic [CSR_ADDR_W-1:0] MTVEC_ADDR = CSR_MTVEC_ADDR,
   parameter logic [CSR_ADDR_W-1:0] MEPC_ADDR  = CSR_MEPC_ADDR
) (
   input  logic            clk,
   input  logic            rst,
   csr_trap_ctrl_if.master bus
);

   state_e      r_state, w_state;
   ctrl_out_t   r_out, w_out;

   logic [2:0]  r_funct3;
   logic [4:0]  r_rs1_field;
   logic [4:0]  r_rd;
   logic [31:0] r_rs1_val;
   logic        r_is_mret;

   logic        w_accept;
   logic [31:0] w_src;

   assign w_accept = bus.req_valid && r_out.req_ready;
   assign w_src    = r_funct3[2] ? {27'b0, r_rs1_field} : r_rs1_val;

   // NOTE: every w_ signal gets a default before the case, so no path leaves a latch.
   always_comb begin
      w_state       = r_state;
      w_out         = '0;
      w_out.csr_op  = CSR_OP_CONST;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               case (req_kind_e'(bus.req_kind))
                  KIND_CSR: begin
                     if (bus.req_insn[13:12] != F3_NONE) begin
                        w_state        = ST_CSR_RD;
                        w_out.csr_r_en = 1'b1;
                        w_out.csr_addr = bus.req_insn[31:20];
                     end
                  end
                  KIND_ECALL: begin
                     w_state         = ST_CAPTURE;
                     w_out.csr_ecall = 1'b1;
                     w_out.csr_pc    = bus.req_pc;
                  end
                  KIND_EBREAK: begin
                     w_state          = ST_CAPTURE;
                     w_out.csr_ebreak = 1'b1;
                     w_out.csr_pc     = bus.req_pc;
                  end
                  KIND_MRET: begin
                     w_state        = ST_CAPTURE;
                     w_out.csr_mret = 1'b1;
                  end
                  KIND_MISAL_LD, KIND_MISAL_ST: begin
                     w_state                  = ST_CAPTURE;
                     w_out.csr_misaligned     = 1'b1;
                     w_out.csr_misalign_store = (bus.req_kind == KIND_MISAL_ST);
                     w_out.csr_in             = bus.req_insn;
                     w_out.csr_pc             = bus.req_pc;
                     w_out.csr_mem_addr       = bus.req_mem_addr;
                     w_out.csr_store_value    = bus.req_store_val;
                     w_out.csr_rd_addr        = bus.req_insn[11:7];
                  end
                  default: w_state = ST_DEAD;
               endcase
            end
         end

         ST_CAPTURE: begin
            w_state        = ST_RD_VEC;
            w_out.csr_r_en = 1'b1;
            w_out.csr_addr = r_is_mret ? MEPC_ADDR : MTVEC_ADDR;
         end

         ST_RD_VEC: begin
            w_state              = ST_REDIRECT;
            w_out.redirect_valid = 1'b1;
            w_out.redirect_pc    = {bus.csr_out[31:2], 2'b00};
         end

         ST_CSR_RD: begin
            // csr_out here is the old value; read-modify-write completes next cycle
            w_state        = ST_CSR_WR;
            w_out.csr_addr = r_out.csr_addr;
            w_out.csr_in   = csr_apply(r_funct3[1:0], bus.csr_out, w_src);
            w_out.csr_w_en = (r_funct3[1:0] == F3_RW) || (r_rs1_field != 5'd0);
            w_out.rd_we    = (r_rd != 5'd0);
            w_out.rd_addr  = r_rd;
            w_out.rd_wdata = bus.csr_out;
         end

         default: w_state = ST_IDLE;
      endcase

      w_out.req_ready = (w_state == ST_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_out   <= '0;
      end else begin
         r_state <= w_state;
         r_out   <= w_out;
      end
   end

   // Request fields are captured only on the accepting edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_funct3    <= '0;
         r_rs1_field <= '0;
         r_rd        <= '0;
         r_rs1_val   <= '0;
         r_is_mret   <= 1'b0;
      end else if (w_accept) begin
         r_funct3    <= bus.req_insn[14:12];
         r_rs1_field <= bus.req_insn[19:15];
         r_rd        <= bus.req_insn[11:7];
         r_rs1_val   <= bus.req_rs1_val;
         r_is_mret   <= (bus.req_kind == KIND_MRET);
      end
   end

   assign bus.req_ready          = r_out.req_ready;
   assign bus.csr_r_en           = r_out.csr_r_en;
   assign bus.csr_w_en           = r_out.csr_w_en;
   assign bus.csr_op             = r_out.csr_op;
   assign bus.csr_in             = r_out.csr_in;
   assign bus.csr_addr           = r_out.csr_addr;
   assign bus.csr_ecall          = r_out.csr_ecall;
   assign bus.csr_ebreak         = r_out.csr_ebreak;
   assign bus.csr_mret           = r_out.csr_mret;
   assign bus.csr_misaligned     = r_out.csr_misaligned;
   assign bus.csr_misalign_store = r_out.csr_misalign_store;
   assign bus.csr_pc             = r_out.csr_pc;
   assign bus.csr_store_value    = r_out.csr_store_value;
   assign bus.csr_mem_addr       = r_out.csr_mem_addr;
   assign bus.csr_rd_addr        = r_out.csr_rd_addr;
   assign bus.rd_we              = r_out.rd_we;
   assign bus.rd_addr            = r_out.rd_addr;
   assign bus.rd_wdata           = r_out.rd_wdata;
   assign bus.redirect_valid     = r_out.redirect_valid;
   assign bus.redirect_pc        = r_out.redirect_pc;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl with a small CSR storage model behind the bus.
module tb_csr_trap_ctrl;
   import csr_trap_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic model_init = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   csr_trap_ctrl_if bus ();

   csr_trap_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] mem [0:4095];

   assign bus.csr_out = bus.csr_r_en ? mem[bus.csr_addr] : 32'h0;

   always @(posedge clk) begin
      if (model_init) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
         mem[12'h340] <= 32'h0000_1234;
         mem[12'h300] <= 32'h0000_1888;
         mem[12'h304] <= 32'h0000_000F;
         mem[12'h305] <= 32'h0000_0801;
         mem[12'h341] <= 32'h0000_0204;
      end else if (bus.csr_w_en) begin
         mem[bus.csr_addr] <= bus.csr_in;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [11:0] csr, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
      return {csr, rs1, f3, rd, 7'h73};
   endfunction

   // Called on a negedge; returns on the negedge inside cycle T1.
   task automatic issue(input logic [2:0] kind, input logic [31:0] pc, input logic [31:0] insn,
                        input logic [31:0] rs1, input logic [14:0] maddr, input logic [31:0] sval);
      int n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bus.req_ready !== 1'b1) check("ready_timeout", {31'b0, bus.req_ready}, 32'h1);
      bus.req_kind      = kind;
      bus.req_pc        = pc;
      bus.req_insn      = insn;
      bus.req_rs1_val   = rs1;
      bus.req_mem_addr  = maddr;
      bus.req_store_val = sval;
      bus.req_valid     = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      bus.req_valid     = 1'b0;
      bus.req_kind      = 3'd0;
      bus.req_pc        = 32'h0;
      bus.req_insn      = 32'h0;
      bus.req_rs1_val   = 32'h0;
      bus.req_mem_addr  = 15'h0;
      bus.req_store_val = 32'h0;

      // Reset state
      @(negedge clk);
      check("rst_ready", {31'b0, bus.req_ready}, 32'h0);
      check("rst_csr_op", {29'b0, bus.csr_op}, 32'h0);
      check("rst_quiet", {28'b0, bus.csr_r_en, bus.csr_w_en, bus.rd_we, bus.redirect_valid}, 32'h0);
      model_init = 1'b0;
      rst        = 1'b1;
      @(negedge clk);
      check("post_rst_ready", {31'b0, bus.req_ready}, 32'h1);
      check("post_rst_csr_op", {29'b0, bus.csr_op}, 32'h1);

      // CSRRW rd=5, csr 0x340 <- 0xA5A5_0000, old 0x1234
      issue(KIND_CSR, 32'h40, enc(12'h340, 5'd1, 3'b001, 5'd5), 32'hA5A5_0000, 15'h0, 32'h0);
      check("rw_t1_ren", {31'b0, bus.csr_r_en}, 32'h1);
      check("rw_t1_addr", {20'b0, bus.csr_addr}, 32'h340);
      check("rw_t1_wen", {31'b0, bus.csr_w_en}, 32'h0);
      check("rw_t1_ready", {31'b0, bus.req_ready}, 32'h0);
      @(negedge clk);
      check("rw_t2_wen", {31'b0, bus.csr_w_en}, 32'h1);
      check("rw_t2_ren", {31'b0, bus.csr_r_en}, 32'h0);
      check("rw_t2_addr", {20'b0, bus.csr_addr}, 32'h340);
      check("rw_t2_csr_in", bus.csr_in, 32'hA5A5_0000);
      check("rw_t2_rd_we", {31'b0, bus.rd_we}, 32'h1);
      check("rw_t2_rd_addr", {27'b0, bus.rd_addr}, 32'h5);
      check("rw_t2_rd_wdata", bus.rd_wdata, 32'h0000_1234);
      @(negedge clk);
      check("rw_t3_mem", mem[12'h340], 32'hA5A5_0000);
      check("rw_t3_rd_we", {31'b0, bus.rd_we}, 32'h0);
      check("rw_t3_ready", {31'b0, bus.req_ready}, 32'h1);

      // CSRRS rs1=0 on mstatus: read only
      issue(KIND_CSR, 32'h44, enc(12'h300, 5'd0, 3'b010, 5'd7), 32'hFFFF_FFFF, 15'h0, 32'h0);
      check("rs0_t1_ren", {31'b0, bus.csr_r_en}, 32'h1);
      @(negedge clk);
      check("rs0_t2_wen", {31'b0, bus.csr_w_en}, 32'h0);
      check("rs0_t2_rd_we", {31'b0, bus.rd_we}, 32'h1);
      check("rs0_t2_rd_wdata", bus.rd_wdata, 32'h0000_1888);
      @(negedge clk);
      check("rs0_t3_wen", {31'b0, bus.csr_w_en}, 32'h0);
      check("rs0_t3_mem", mem[12'h300], 32'h0000_1888);

      // CSRRCI zimm=3, rd=0, on 0xF
      issue(KIND_CSR, 32'h48, enc(12'h304, 5'd3, 3'b111, 5'd0), 32'hFFFF_FFFF, 15'h0, 32'h0);
      @(negedge clk);
      check("rci_t2_wen", {31'b0, bus.csr_w_en}, 32'h1);
      check("rci_t2_csr_in", bus.csr_in, 32'h0000_000C);
      check("rci_t2_rd_we", {31'b0, bus.rd_we}, 32'h0);
      @(negedge clk);
      check("rci_t3_mem", mem[12'h304], 32'h0000_000C);

      // funct3=0: no access, straight back to IDLE
      issue(KIND_CSR, 32'h4C, enc(12'h340, 5'd1, 3'b000, 5'd5), 32'h1111_1111, 15'h0, 32'h0);
      check("f3z_ren", {31'b0, bus.csr_r_en}, 32'h0);
      check("f3z_ready", {31'b0, bus.req_ready}, 32'h1);

      // ECALL pc=0x100, mtvec=0x801
      issue(KIND_ECALL, 32'h100, 32'h0000_0073, 32'h0, 15'h0, 32'h0);
      check("ecall_t1_strobe", {28'b0, bus.csr_ecall, bus.csr_ebreak, bus.csr_mret, bus.csr_misaligned}, 32'h8);
      check("ecall_t1_pc", bus.csr_pc, 32'h100);
      check("ecall_t1_ready", {31'b0, bus.req_ready}, 32'h0);
      @(negedge clk);
      check("ecall_t2_ecall", {31'b0, bus.csr_ecall}, 32'h0);
      check("ecall_t2_ren", {31'b0, bus.csr_r_en}, 32'h1);
      check("ecall_t2_addr", {20'b0, bus.csr_addr}, 32'h305);
      @(negedge clk);
      check("ecall_t3_redir", {31'b0, bus.redirect_valid}, 32'h1);
      check("ecall_t3_pc", bus.redirect_pc, 32'h800);
      @(negedge clk);
      check("ecall_t4_redir", {31'b0, bus.redirect_valid}, 32'h0);
      check("ecall_t4_ready", {31'b0, bus.req_ready}, 32'h1);

      // Misaligned store
      issue(KIND_MISAL_ST, 32'h180, 32'h00A1_2023, 32'h0, 15'h0203, 32'hDEAD_BEEF);
      check("mst_t1_strobe", {28'b0, bus.csr_ecall, bus.csr_ebreak, bus.csr_mret, bus.csr_misaligned}, 32'h1);
      check("mst_t1_store", {31'b0, bus.csr_misalign_store}, 32'h1);
      check("mst_t1_maddr", {17'b0, bus.csr_mem_addr}, 32'h203);
      check("mst_t1_sval", bus.csr_store_value, 32'hDEAD_BEEF);
      check("mst_t1_csr_in", bus.csr_in, 32'h00A1_2023);
      check("mst_t1_pc", bus.csr_pc, 32'h180);
      @(negedge clk);
      check("mst_t2_mis", {31'b0, bus.csr_misaligned}, 32'h0);
      check("mst_t2_addr", {20'b0, bus.csr_addr}, 32'h305);
      @(negedge clk);
      check("mst_t3_pc", bus.redirect_pc, 32'h800);

      // MRET with a request held while busy
      issue(KIND_MRET, 32'h300, 32'h3020_0073, 32'h0, 15'h0, 32'h0);
      check("mret_t1_strobe", {28'b0, bus.csr_ecall, bus.csr_ebreak, bus.csr_mret, bus.csr_misaligned}, 32'h2);
      bus.req_kind  = KIND_EBREAK;
      bus.req_valid = 1'b1;
      @(negedge clk);
      check("mret_t2_addr", {20'b0, bus.csr_addr}, 32'h341);
      check("mret_t2_ebreak", {31'b0, bus.csr_ebreak}, 32'h0);
      @(negedge clk);
      check("mret_t3_redir", {31'b0, bus.redirect_valid}, 32'h1);
      check("mret_t3_pc", bus.redirect_pc, 32'h204);
      check("mret_t3_ebreak", {31'b0, bus.csr_ebreak}, 32'h0);
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("mret_t4_ready", {31'b0, bus.req_ready}, 32'h1);
      check("mret_t4_ebreak", {31'b0, bus.csr_ebreak}, 32'h0);

      // Illegal kind: one dead cycle, nothing driven
      issue(3'd6, 32'h400, 32'h0, 32'h0, 15'h0, 32'h0);
      check("ill_t1_quiet", {24'b0, bus.csr_ecall, bus.csr_ebreak, bus.csr_mret, bus.csr_misaligned,
                             bus.csr_r_en, bus.csr_w_en, bus.rd_we, bus.redirect_valid}, 32'h0);
      check("ill_t1_ready", {31'b0, bus.req_ready}, 32'h0);
      @(negedge clk);
      check("ill_t2_ready", {31'b0, bus.req_ready}, 32'h1);

      // Reset during CSR_WR
      issue(KIND_CSR, 32'h50, enc(12'h340, 5'd1, 3'b001, 5'd5), 32'h5555_5555, 15'h0, 32'h0);
      @(negedge clk);
      check("arst_pre_wen", {31'b0, bus.csr_w_en}, 32'h1);
      #2 rst = 1'b0;
      #1;
      check("arst_wen", {31'b0, bus.csr_w_en}, 32'h0);
      check("arst_rd_we", {31'b0, bus.rd_we}, 32'h0);
      check("arst_ready", {31'b0, bus.req_ready}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("arst_post_ready", {31'b0, bus.req_ready}, 32'h1);
      check("arst_mem_kept", mem[12'h340], 32'hA5A5_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
